issue_buffer: RTL
=================

# issue_buffer

Dual-width instruction buffer between fetch and the dual-issue stage. Accepts up to two instructions per cycle from fetch and presents the two oldest to the issue stage as slot-0/slot-1 candidates. Consumes zero, one or two entries per cycle depending on the issue stage's stall and slot-1 special-stall outputs. A slot-1 instruction held back by a dependence or slot conflict is therefore re-presented as the next cycle's slot-0 candidate, paired with the following instruction.

## Interface
- DEPTH, 8: entries; power of two, ≥4.
- PTR_W, $clog2(DEPTH): pointer width. Count register is PTR_W+1 bits.
- clock_i  in  1  single clock; all state on rising edge.
- reset_n_i  in  1  reset; asynchronous and active-low.
- flush_i  in  1  redirect; empties buffer.
- fetch_valid_i  in  2  bit0 = inst0 valid, bit1 = inst1 valid; bit1 is ignored when bit0 = 0.
- fetch_inst0_i / fetch_inst1_i  in  32  instructions; inst0 is older.
- fetch_pc0_i / fetch_pc1_i  in  32  matching PCs.
- fetch_ready_o  out  1  buffer can take two entries this cycle.
- issue_valid0_o / issue_valid1_o  out  1  candidate valid.
- issue_inst0_o / issue_inst1_o  out  32  oldest and second-oldest instruction; 0 when invalid.
- issue_pc0_o / issue_pc1_o  out  32  matching PCs; 0 when invalid.
- stall_i  in  1  whole-pipe stall; nothing consumed.
- issue1_special_stall_i  in  1  slot 1 held; only the oldest entry is consumed.
- count_o  out  PTR_W+1  current occupancy.

## Operation
- State:
  - entry array (inst, pc);
  - head and tail pointers, PTR_W bits, wrapping modulo DEPTH;
  - count.
- Push:
  - push_n = 0 if fetch_ready_o = 0, if fetch_valid_i[0] = 0, or if flush_i = 1.
  - Otherwise push_n = 1 + fetch_valid_i[1].
  - inst0 is written at tail, inst1 at tail+1 (wrapping).
  - When fetch_ready_o = 0, fetch holds its inputs; no data is dropped silently.
- fetch_ready_o = (count ≤ DEPTH−2), derived from registered count only.
- Pop:
  - pop_n = 0 if stall_i, flush_i or issue_valid0_o = 0.
  - Else pop_n = 1 if issue_valid1_o = 0 or issue1_special_stall_i = 1.
  - Else pop_n = 2.
  - head advances by pop_n.
- issue_valid0_o = (count ≥ 1); issue_valid1_o = (count ≥ 2). Outputs read entries at head and head+1.
- No bypass: an entry pushed in cycle N is first visible as a candidate in cycle N+1.
- Simultaneous push and pop are legal:
  - count_next = count + push_n − pop_n;
  - a pop never touches the entries written in the same cycle.
- Flush:
  - count, head and tail go to 0 next cycle;
  - any push in the same cycle is discarded;
  - flush has priority over stall_i.
- Invariant: 0 ≤ count ≤ DEPTH. Overflow is impossible by the ready rule. Underflow is impossible by the pop rule.

## Timing
- Reset (async assert, sync release):
  - count = 0, head = tail = 0;
  - issue_valid0_o = issue_valid1_o = 0, issue data outputs = 0;
  - fetch_ready_o = 1, count_o = 0.
  - Entry array contents are don't-care.
- Reset asserted mid-operation empties the buffer immediately, in the same cycle, asynchronously.
- Latency is one cycle, fetch push to issue candidate.
- Throughput: 2 instr/cycle sustained when stall_i = 0 and issue1_special_stall_i = 0.
- Candidate outputs and fetch_ready_o are combinational from registers only. stall_i and issue1_special_stall_i affect state only; no combinational path from them to outputs.
- Wrap: pointers roll from DEPTH−1 to 0. A pair may straddle the wrap (tail = DEPTH−1 writes entries DEPTH−1 and 0).

## Structure
- src/defs.v gains ISSUE_BUF_DEPTH (default 8) and field-range macros for the entry {pc, inst}.
- Sub-module pair_fifo_mem:
  - DEPTH × 64-bit storage;
  - two write ports (addr, data, enable);
  - two combinational read ports.
  - It is reusable for a future decode-side buffer.
- Pointer and count arithmetic stays in issue_buffer.

## Test plan
- Fill then drain:
  - Push pairs (A,B) and (C,D) with stall_i = 0.
  - Required: candidates (A,B) in cycle 1 and (C,D) in cycle 2.
  - count_o reads 2, then 2, then 0, with valids 0 after.
- Special stall:
  - Buffer holds A,B,C,D; pulse issue1_special_stall_i for one cycle.
  - Required: next candidates are (B,C), then (D, invalid); count goes 4→3→1.
- Full and wrap, with DEPTH = 8:
  - Push 4 pairs under stall_i = 1.
  - Required: count_o = 8, fetch_ready_o = 0. A fifth pair is not accepted and the held inputs are unchanged.
  - Release the stall and push a pair straddling the wrap (tail = 7 after odd single pushes).
  - Required: order is preserved.
- Single push:
  - fetch_valid_i = 2'b01 with X, then 2'b10 with Y.
  - Required: only X is stored; count_o = 1, issue_valid1_o = 0.
- Flush with push:
  - count = 5, flush_i = 1 together with a valid pair.
  - Required: next cycle count_o = 0, valids = 0, fetch_ready_o = 1, pair absent.
- Async reset:
  - Assert reset_n_i low mid-clock while count = 6.
  - Required: outputs are at reset values before the next edge and stay there until after release.

Source files
------------

// File: rtl/issue_buffer_pkg.sv
// Shared types and sizes for the fetch-to-issue instruction buffer.
package issue_buffer_pkg;

    localparam int unsigned IssueBufDepth = 8;
    localparam int unsigned InstW         = 32;
    localparam int unsigned PcW           = 32;
    localparam int unsigned EntryW        = PcW + InstW;

    // Stored entry layout: pc in the upper half, inst in the lower half.
    typedef struct packed {
        logic [PcW-1:0]   pc;
        logic [InstW-1:0] inst;
    } entry_t;

    function automatic entry_t make_entry(logic [PcW-1:0] pc, logic [InstW-1:0] inst);
        entry_t e;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

endpackage

// File: rtl/issue_buffer_if.sv
// Fetch-side and issue-side signal bundle for issue_buffer.
interface issue_buffer_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             flush_i;
    logic [1:0]       fetch_valid_i;
    logic [31:0]      fetch_inst0_i;
    logic [31:0]      fetch_inst1_i;
    logic [31:0]      fetch_pc0_i;
    logic [31:0]      fetch_pc1_i;
    logic             fetch_ready_o;
    logic             issue_valid0_o;
    logic             issue_valid1_o;
    logic [31:0]      issue_inst0_o;
    logic [31:0]      issue_inst1_o;
    logic [31:0]      issue_pc0_o;
    logic [31:0]      issue_pc1_o;
    logic             stall_i;
    logic             issue1_special_stall_i;
    logic [PTR_W:0]   count_o;

    // Environment side: fetch, issue stage and redirect control.
    modport master (
        output flush_i, fetch_valid_i, fetch_inst0_i, fetch_inst1_i, fetch_pc0_i, fetch_pc1_i,
        output stall_i, issue1_special_stall_i,
        input  fetch_ready_o, issue_valid0_o, issue_valid1_o, issue_inst0_o, issue_inst1_o,
        input  issue_pc0_o, issue_pc1_o, count_o
    );

    // Buffer side.
    modport slave (
        input  flush_i, fetch_valid_i, fetch_inst0_i, fetch_inst1_i, fetch_pc0_i, fetch_pc1_i,
        input  stall_i, issue1_special_stall_i,
        output fetch_ready_o, issue_valid0_o, issue_valid1_o, issue_inst0_o, issue_inst1_o,
        output issue_pc0_o, issue_pc1_o, count_o
    );

endinterface

// File: rtl/pair_fifo_mem.sv
// DEPTH-entry storage with two write ports and two combinational read ports.
module pair_fifo_mem
    import issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = EntryW,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [WIDTH-1:0]  wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [WIDTH-1:0]  rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents need no reset; the owner tracks which entries are live.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/issue_buffer.sv
// Dual-width instruction buffer: up to two pushes from fetch and two pops to issue per cycle.
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = IssueBufDepth
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    issue_buffer_if.slave bus
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned COUNT_W = PTR_W + 1;
    localparam logic [COUNT_W-1:0] ReadyMax = COUNT_W'(DEPTH - 2);
    localparam logic [COUNT_W-1:0] CountTwo = COUNT_W'(2);

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [1:0]         push_n, pop_n;
    logic               fetch_ready, valid0, valid1;
    entry_t             rd0, rd1, wd0, wd1;

    // Everything visible to fetch/issue derives from registered state only.
    assign fetch_ready = (count_q <= ReadyMax);
    assign valid0      = (count_q != '0);
    assign valid1      = (count_q >= CountTwo);

    always_comb begin
        push_n = 2'd0;
        if (fetch_ready && bus.fetch_valid_i[0] && !bus.flush_i) begin
            push_n = bus.fetch_valid_i[1] ? 2'd2 : 2'd1;
        end

        pop_n = 2'd0;
        if (!bus.stall_i && !bus.flush_i && valid0) begin
            pop_n = (!valid1 || bus.issue1_special_stall_i) ? 2'd1 : 2'd2;
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_q + COUNT_W'(push_n) - COUNT_W'(pop_n);
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign wd0 = make_entry(bus.fetch_pc0_i, bus.fetch_inst0_i);
    assign wd1 = make_entry(bus.fetch_pc1_i, bus.fetch_inst1_i);

    // Writes land only in free slots, so a same-cycle pop never sees them.
    pair_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_mem (
        .clk    (clock_i),
        .we0    (push_n != 2'd0),
        .waddr0 (tail_q),
        .wdata0 (wd0),
        .we1    (push_n == 2'd2),
        .waddr1 (tail_q + PTR_W'(1)),
        .wdata1 (wd1),
        .raddr0 (head_q),
        .rdata0 (rd0),
        .raddr1 (head_q + PTR_W'(1)),
        .rdata1 (rd1)
    );

    assign bus.fetch_ready_o  = fetch_ready;
    assign bus.issue_valid0_o = valid0;
    assign bus.issue_valid1_o = valid1;
    assign bus.issue_inst0_o  = valid0 ? rd0.inst : '0;
    assign bus.issue_pc0_o    = valid0 ? rd0.pc   : '0;
    assign bus.issue_inst1_o  = valid1 ? rd1.inst : '0;
    assign bus.issue_pc1_o    = valid1 ? rd1.pc   : '0;
    assign bus.count_o        = count_q;

endmodule
